// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder / scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest selector the one-hot helper supports; callers truncate the result.
  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  // Index to one-hot vector at the maximum supported width.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    logic [MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts 0..limit and pulses step on the last cycle of each dwell.
// Latency: limit is captured on clear or on each step; step is combinational from the count.
// Backpressure: none; clear holds the counter at zero and suppresses step.
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [DWELL_W-1:0] load_val,
  output logic               step
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] limit;

  assign step = ~clear & (cnt == limit);

  // Count up; reload the limit whenever the count restarts so a new dwell only affects the next step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      limit <= '0;
    end else if (clear || step) begin
      cnt   <= '0;
      limit <= load_val;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with a direct (handshaked) mode and an auto-scan mode.
// Latency: one cycle from handshake or scan step to out/cur_sel/out_valid/wrap.
// Backpressure: in_ready drops while scanning, disabled, or in reset; no stall otherwise.
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in_sel,
  output logic                in_ready,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [(1<<N)-1:0]   out,
  output logic                out_valid,
  output logic [N-1:0]        cur_sel,
  output logic                wrap
);

  localparam int W = 1 << N;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   idx_d;
  logic           wrap_d;
  logic [W-1:0]   out_d;
  logic           hs;
  logic           scan_hold;
  logic           step;

  // Staying in SCAN this cycle; anything else restarts the dwell timer with a fresh dwell.
  assign scan_hold = (state_q == ST_SCAN) & en & (mode == MODE_SCAN);
  assign in_ready  = rst_n & en & (mode == MODE_DIRECT) & (state_q != ST_SCAN);
  assign hs        = in_valid & in_ready;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (~scan_hold),
    .load_val (dwell),
    .step     (step)
  );

  // Next state, next index and wrap pulse; scan entry beats a simultaneous in_valid.
  always_comb begin
    state_d = state_q;
    idx_d   = cur_sel;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DIRECT: begin
        if (en && mode == MODE_SCAN) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (hs) begin
          state_d = ST_DIRECT;
          idx_d   = in_sel;
        end
      end
      ST_SCAN: begin
        if (!scan_hold) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (step) begin
          idx_d  = cur_sel + 1'b1;
          wrap_d = (cur_sel == {N{1'b1}});
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // One-hot image of the next index; zero whenever the block is heading to IDLE.
  always_comb begin
    out_d = '0;
    if (state_d != ST_IDLE) begin
      out_d = W'(onehot(MAX_N'(idx_d)));
    end
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      cur_sel   <= '0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out       <= out_d;
      out_valid <= (state_d != ST_IDLE);
      cur_sel   <= idx_d;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: doc/decoder_n_scan.md
# decoder_n_scan

Parametrised, registered N-to-2^N one-hot decoder and successor to the combinational 2x4 decoder. It has two modes. In direct mode it decodes a selector accepted through a valid/ready handshake. In scan mode an internal sequencer walks the one-hot output through every position, with a programmable dwell time. It drives channel/row enables (mux selects, LED or keypad row scanning) in the challenge designs, where a glitch-free registered one-hot output is required.

## Interface
- `N`, 2: selector width; output width is 2^N (N ≥ 1).
- `DWELL_W`, 4: width of the dwell-count input.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low forces the block to IDLE.
- `mode`  in  1  0 = direct, 1 = scan.
- `in_valid`  in  1  selector valid (direct mode).
- `in_sel`  in  N  selector to decode.
- `in_ready`  out  1  selector accepted when `in_valid & in_ready`.
- `dwell`  in  DWELL_W  scan step length minus 1, in cycles.
- `out`  out  2^N  registered one-hot output, or all-zero.
- `out_valid`  out  1  registered; high iff `out` is non-zero.
- `cur_sel`  out  N  registered binary index of the active bit (0 when `out` = 0).
- `wrap`  out  1  registered one-cycle pulse on the scan step from index 2^N-1 to 0.

## Operation
- States are IDLE, DIRECT and SCAN. Reset enters IDLE.
- Reset values: `out` = 0, `out_valid` = 0, `cur_sel` = 0, `wrap` = 0. `in_ready` is 0 while `rst_n` is low.
- `in_ready` = `en & ~mode & (state != SCAN)`. It is combinational from the inputs and state.
- **IDLE:** `out` = 0.
  - If `en & mode`: go to SCAN with index 0 and load the dwell counter.
  - Else if a handshake occurs: go to DIRECT.
- **DIRECT:** `out` holds the last accepted selector.
  - Each handshake replaces it.
  - If `en` is low: go to IDLE.
  - If `mode` = 1: go to SCAN at index 0.
- **SCAN:** a dwell counter counts 0..`dwell`.
  - When the counter reaches `dwell`, the index increments modulo 2^N and the counter clears.
  - `dwell` is sampled at each counter reload, so a change takes effect from the next step.
  - If `en` is low or `mode` = 0: go to IDLE. `en` has priority.
  - `in_valid` is ignored in SCAN.
- `out` = 1 << index. It is never more than one-hot.
- `wrap` is asserted in the same cycle that `out` returns to bit 0 from a scan wrap. It is not asserted on SCAN entry.

## Timing
- Direct latency: a handshake at edge k gives the new `out`, `cur_sel` and `out_valid` after edge k. Back-to-back handshakes update every cycle.
- SCAN entry at edge k: `out` = bit 0 after edge k.
- Each scan position is held `dwell`+1 cycles. The full period is 2^N·(`dwell`+1) cycles.
- `dwell` = 0 advances the index every cycle.
- Leaving to IDLE: `out` = 0 after the next edge. The dwell counter and index clear.
- Re-entering SCAN always restarts at index 0 with a fresh dwell count.
- Mid-operation reset: outputs go to their reset values immediately (asynchronously). After `rst_n` deasserts, the first active edge behaves as from IDLE.
- Simultaneous `mode` rising and `in_valid` in IDLE or DIRECT: `in_ready` = 0, so there is no handshake and the block enters SCAN.

## Structure
- Package `decoder_pkg`:
  - state encoding constants `ST_IDLE`, `ST_DIRECT`, `ST_SCAN`;
  - mode constants `MODE_DIRECT`, `MODE_SCAN`;
  - one-hot encode function (index → 2^N vector).
- Sub-module `dwell_counter` (parameter `DWELL_W`):
  - inputs: `clk`, `rst_n`, `clear`, `load_val`;
  - output: `step` pulse when the count reaches the loaded value.
- The top level holds the FSM, the index register and the output registers.

## Test plan
1. **Direct sweep.** N=2, mode 0, en 1; handshake `in_sel` 00, 11, 01, 00, 10 on consecutive cycles.
   - Required: `out` = 0001, 1000, 0010, 0001, 0100, each one cycle after its handshake.
   - Required: `cur_sel` matches the selector and `out_valid` = 1.
2. **Scan, dwell 0.** N=2, `dwell` = 0, mode 1.
   - Required: `out` = 0001, 0010, 0100, 1000, 0001, changing every cycle.
   - Required: `wrap` = 1 only on the cycle `out` returns to 0001.
3. **Scan, dwell 2.** N=2, `dwell` = 2.
   - Required: each position is held 3 cycles and the period is 12 cycles.
   - Changing `dwell` to 0 mid-step takes effect only at the next step.
4. **Enable drop.** Drop `en` in DIRECT (`out` = 0100).
   - Required: `out` = 0000 and `out_valid` = 0 next cycle.
   - Required: `in_ready` = 0 while `en` = 0, and an `in_valid` pulse then has no effect.
5. **Reset mid-scan.** N=3, scan at index 5; assert `rst_n` low between edges.
   - Required: `out` = 0, `cur_sel` = 0 and `wrap` = 0 immediately.
   - Required: after release with mode 1, the scan restarts at 00000001.
6. **Wide direct and mode switch.** N=3, direct `in_sel` = 5, then switch to mode 1 in the same cycle as `in_valid` with `in_sel` = 2.
   - Required: `out` = 00100000 after the direct handshake.
   - Required: after the switch, no handshake occurs and `out` = 00000001.
